lsu_ctrl: RTL and testbench

- Load/store controller between the execute stage and the data-memory bus of the RV32I core.
- Accepts one LOAD/STORE operation at a time and validates alignment and funct3.
- Drives a req/gnt/rvalid memory handshake with byte enables and store-data replication.
- Returns sign- or zero-extended load data, and stalls the pipeline until the access completes.

---
 rtl/lsu_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: validates the op, runs the req/gnt/rvalid
// data-bus handshake and extends load data back to the pipeline.
module lsu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            op_valid_i,
    input  logic            is_load_i,
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic            done_o,
    output logic            exc_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RD
    } state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;

    logic              f3_ok;
    logic              align_ok;
    logic              op_ok;
    logic [3:0]        st_be;
    logic [XLEN-1:0]   st_wdata;
    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_ext;

    // funct3[1:0] encodes the access size for both loads and stores
    always_comb begin
        f3_ok = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = is_load_i;
            default:                f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        align_ok = 1'b0;
        case (funct3_i[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~addr_i[0];
            2'b10:   align_ok = (addr_i[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    assign op_ok = (is_load_i ^ is_store_i) & f3_ok & align_ok;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr_i[1:0];
                st_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << addr_i[1:0];
                st_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata_i;
            end
        endcase
    end

    assign ld_shift = dmem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        ld_ext = ld_shift;
        case (f3_q)
            3'b000:  ld_ext = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        off_d       = off_q;
        done_o      = 1'b0;
        exc_o       = 1'b0;
        load_data_o = '0;
        unique case (state_q)
            IDLE: begin
                if (op_valid_i) begin
                    if (!op_ok) begin
                        done_o = 1'b1;
                        exc_o  = 1'b1;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = is_store_i;
                        addr_d  = {addr_i[XLEN-1:2], 2'b00};
                        be_d    = is_store_i ? st_be : 4'b1111;
                        wdata_d = is_store_i ? st_wdata : '0;
                        f3_d    = funct3_i;
                        off_d   = addr_i[1:0];
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    be_d    = 4'b0000;
                    wdata_d = '0;
                    if (we_q) begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (dmem_rvalid_i) begin
                    done_o      = 1'b1;
                    load_data_o = ld_ext;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end

    assign stall_o      = op_valid_i & ~done_o;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-lane reference model plus directed transactions
// with hand-computed literal results.
module tb_lsu_ctrl;

    logic        clk;
    logic        arst_n;
    logic        op_valid_i;
    logic        is_load_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic        exc_o;
    logic [31:0] load_data_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    lsu_ctrl #(.XLEN(32)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .op_valid_i   (op_valid_i),
        .is_load_i    (is_load_i),
        .is_store_i   (is_store_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .exc_o        (exc_o),
        .load_data_o  (load_data_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    bit          chk_en = 0;
    bit          exp_stall = 0, exp_done = 0, exp_exc = 0;
    bit          exp_req = 0, exp_we = 0;
    logic [31:0] exp_addr = '0, exp_wd = '0, exp_ld = '0;
    logic [3:0]  exp_be = '0;

    int          req_cnt = 0, done_cnt = 0, exc_cnt = 0, stall_cnt = 0;
    logic [31:0] cap_ld = '0, cap_addr = '0, cap_wd = '0;
    logic [3:0]  cap_be = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit legal(bit ld, bit st, logic [2:0] f3, logic [31:0] a);
        if (ld == st) return 0;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
        return (int'(a[1:0]) % nbytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(bit st, logic [2:0] f3, logic [31:0] a);
        logic [3:0] be;
        int o = int'(a[1:0]);
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++) be[i] = !st || (i >= o && i < o + n);
        return be;
    endfunction

    function automatic logic [31:0] m_wd(bit st, logic [2:0] f3, logic [31:0] w);
        logic [31:0] wd = '0;
        int n = nbytes(f3);
        if (st)
            for (int i = 0; i < 4; i++) wd[8*i +: 8] = w[8*(i % n) +: 8];
        return wd;
    endfunction

    function automatic logic [31:0] m_ld(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
        longint v = 0;
        int o = int'(a[1:0]);
        int n = nbytes(f3);
        for (int k = 0; k < n; k++) v = v | (longint'(rd[8*(o+k) +: 8]) << (8*k));
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1)))
            v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (dmem_req_o) begin
                req_cnt++;
                cap_addr = dmem_addr_o;
                cap_be   = dmem_be_o;
                cap_wd   = dmem_wdata_o;
            end
            if (done_o) begin
                done_cnt++;
                cap_ld = load_data_o;
            end
            if (exc_o) exc_cnt++;
            if (stall_o) stall_cnt++;
            if (chk_en) begin
                check("stall_o", 32'(stall_o), 32'(exp_stall));
                check("done_o", 32'(done_o), 32'(exp_done));
                check("exc_o", 32'(exc_o), 32'(exp_exc));
                check("load_data_o", load_data_o, exp_ld);
                check("dmem_req_o", 32'(dmem_req_o), 32'(exp_req));
                if (exp_req) begin
                    check("dmem_we_o", 32'(dmem_we_o), 32'(exp_we));
                    check("dmem_addr_o", dmem_addr_o, exp_addr);
                    check("dmem_be_o", 32'(dmem_be_o), 32'(exp_be));
                    check("dmem_wdata_o", dmem_wdata_o, exp_wd);
                end
            end
        end
    endtask

    task automatic set_idle_exp();
        exp_stall = 0; exp_done = 0; exp_exc = 0;
        exp_req = 0; exp_ld = '0;
    endtask

    // bus lines are deliberately active while idle: they must be ignored
    task automatic idle(int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            op_valid_i = 0; is_load_i = 0; is_store_i = 0;
            dmem_gnt_i = 1; dmem_rvalid_i = 1;
            dmem_rdata_i = $urandom;
            set_idle_exp();
        end
    endtask

    task automatic run_op(bit ld, bit st, logic [2:0] f3, logic [31:0] a,
                          logic [31:0] wd, int gw, int rw, logic [31:0] rd);
        bit ok = legal(ld, st, f3, a);
        @(posedge clk); #1;
        op_valid_i = 1; is_load_i = ld; is_store_i = st;
        funct3_i = f3; addr_i = a; wdata_i = wd;
        dmem_gnt_i = 0; dmem_rvalid_i = 0;
        set_idle_exp();
        exp_done = !ok; exp_exc = !ok; exp_stall = ok;
        if (!ok) return;
        for (int c = 0; c <= gw; c++) begin
            @(posedge clk); #1;
            dmem_gnt_i = (c == gw); dmem_rvalid_i = 0;
            exp_req = 1; exp_we = st;
            exp_addr = {a[31:2], 2'b00};
            exp_be = m_be(st, f3, a);
            exp_wd = m_wd(st, f3, wd);
            exp_done = st && (c == gw);
            exp_stall = !exp_done;
        end
        if (ld) begin
            for (int c = 0; c <= rw; c++) begin
                @(posedge clk); #1;
                dmem_gnt_i = 0; dmem_rvalid_i = (c == rw);
                dmem_rdata_i = (c == rw) ? rd : 32'h5A5A0F0F;
                exp_req = 0;
                exp_done = (c == rw);
                exp_stall = !exp_done;
                exp_ld = exp_done ? m_ld(f3, a, rd) : '0;
            end
        end
    endtask

    int r0, d0, e0, s0;

    initial begin
        arst_n = 0; op_valid_i = 0; is_load_i = 0; is_store_i = 0;
        funct3_i = 0; addr_i = 0; wdata_i = 0;
        dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
        fork compare_loop(); join_none
        #12;
        check("rst_req", 32'(dmem_req_o), 0);
        check("rst_we", 32'(dmem_we_o), 0);
        check("rst_addr", dmem_addr_o, 0);
        check("rst_be", 32'(dmem_be_o), 0);
        check("rst_wdata", dmem_wdata_o, 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_exc", 32'(exc_o), 0);
        check("rst_ld", load_data_o, 0);
        #10 arst_n = 1;
        chk_en = 1;
        idle(2);

        // SW with two wait states
        r0 = req_cnt; d0 = done_cnt; s0 = stall_cnt;
        run_op(0, 1, 3'b010, 32'h1004, 32'hDEADBEEF, 2, 0, 0);
        idle(1);
        check("sw_req_cycles", req_cnt - r0, 3);
        check("sw_stall_cycles", stall_cnt - s0, 3);
        check("sw_done_pulses", done_cnt - d0, 1);
        check("sw_addr", cap_addr, 32'h1004);
        check("sw_be", 32'(cap_be), 32'hF);
        check("sw_wdata", cap_wd, 32'hDEADBEEF);

        // LB / LBU on top byte
        run_op(1, 0, 3'b000, 32'h2003, 0, 1, 2, 32'h80123456);
        idle(1);
        check("lb_data", cap_ld, 32'hFFFFFF80);
        run_op(1, 0, 3'b100, 32'h2003, 0, 0, 0, 32'h80123456);
        idle(1);
        check("lbu_data", cap_ld, 32'h00000080);

        // SB / SH lane replication
        run_op(0, 1, 3'b000, 32'h3002, 32'h000000A5, 0, 0, 0);
        idle(1);
        check("sb_be", 32'(cap_be), 32'b0100);
        check("sb_wdata", cap_wd, 32'hA5A5A5A5);
        run_op(0, 1, 3'b001, 32'h3002, 32'h00001234, 1, 0, 0);
        idle(1);
        check("sh_be", 32'(cap_be), 32'b1100);
        check("sh_wdata", cap_wd, 32'h12341234);

        // exceptions: no bus traffic
        r0 = req_cnt; d0 = done_cnt; e0 = exc_cnt;
        run_op(1, 0, 3'b101, 32'h4001, 0, 0, 0, 0);
        run_op(1, 0, 3'b010, 32'h4002, 0, 0, 0, 0);
        run_op(1, 0, 3'b011, 32'h4000, 0, 0, 0, 0);
        run_op(0, 0, 3'b010, 32'h4000, 0, 0, 0, 0);
        run_op(0, 1, 3'b100, 32'h4000, 0, 0, 0, 0);
        idle(1);
        check("exc_count", exc_cnt - e0, 5);
        check("exc_done_count", done_cnt - d0, 5);
        check("exc_no_req", req_cnt - r0, 0);

        // reset while waiting for read data
        d0 = done_cnt;
        @(posedge clk); #1;
        op_valid_i = 1; is_load_i = 1; is_store_i = 0;
        funct3_i = 3'b010; addr_i = 32'h6000;
        dmem_gnt_i = 0; dmem_rvalid_i = 0;
        set_idle_exp(); exp_stall = 1;
        @(posedge clk); #1;
        dmem_gnt_i = 1;
        exp_req = 1; exp_we = 0; exp_addr = 32'h6000;
        exp_be = 4'hF; exp_wd = 0;
        @(posedge clk); #1;
        dmem_gnt_i = 0;
        exp_req = 0;
        @(negedge clk); #1;
        chk_en = 0;
        arst_n = 0;
        #1;
        check("arst_req", 32'(dmem_req_o), 0);
        check("arst_done", 32'(done_o), 0);
        check("arst_ld", load_data_o, 0);
        check("arst_be", 32'(dmem_be_o), 0);
        op_valid_i = 0; is_load_i = 0;
        #1 arst_n = 1;
        @(posedge clk); #1;
        dmem_rvalid_i = 1; dmem_rdata_i = 32'h12345678;
        set_idle_exp();
        chk_en = 1;
        idle(1);
        check("arst_no_done", done_cnt - d0, 0);
        run_op(0, 1, 3'b010, 32'h6004, 32'hCAFEF00D, 0, 0, 0);
        idle(1);
        check("arst_then_sw", cap_wd, 32'hCAFEF00D);

        // back-to-back SW then LH
        d0 = done_cnt;
        run_op(0, 1, 3'b010, 32'h5000, 32'h11223344, 0, 0, 0);
        run_op(1, 0, 3'b001, 32'h5002, 0, 0, 0, 32'hBEEF0000);
        idle(1);
        check("b2b_done_pulses", done_cnt - d0, 2);
        check("lh_data", cap_ld, 32'hFFFFBEEF);

        // model sweep
        run_op(1, 0, 3'b101, 32'h7002, 0, 0, 1, 32'h8001ABCD);
        run_op(1, 0, 3'b000, 32'h7001, 0, 1, 0, 32'h00007F00);
        idle(1);
        check("lb_pos_data", cap_ld, 32'h0000007F);
        run_op(1, 0, 3'b010, 32'h7000, 0, 0, 0, 32'h89ABCDEF);
        run_op(0, 1, 3'b001, 32'h7000, 32'hFFFF5678, 0, 0, 0);
        run_op(0, 1, 3'b000, 32'h7001, 32'h000000C3, 1, 0, 0);
        run_op(1, 0, 3'b001, 32'h7000, 0, 0, 0, 32'h00007FFF);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
